// File: rtl/i2s_tx_sample_unpacker_if.sv
// ---------------------------------------------------------------------------
// i2s_tx_sample_unpacker_if
//
// Bundles everything between the sample unpacker and its neighbours: the
// packed-word stream from the TX data FIFO, the sample stream towards the
// I2S TX DSP channel, the static configuration and the status outputs.
// Signal names match the unpacker's port names so a port list can be read
// straight across.
//
// Signals:
//   data_i / data_valid_i / data_ready_o       packed 32-bit word stream in
//   sample_o / sample_valid_o / sample_ready_i head-of-FIFO sample stream out
//   level_o                                    samples currently buffered
//   err_underrun_o                             sticky underrun flag
//   cfg_en_i / cfg_word_size_i / cfg_sign_ext_i configuration
//
// Modports:
//   slave  - the unpacker itself
//   master - the environment driving the unpacker (upstream, consumer, cfg)
// ---------------------------------------------------------------------------
interface i2s_tx_sample_unpacker_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]   data_i;
    logic          data_valid_i;
    logic          data_ready_o;
    logic [31:0]   sample_o;
    logic          sample_valid_o;
    logic          sample_ready_i;
    logic [LW-1:0] level_o;
    logic          err_underrun_o;
    logic          cfg_en_i;
    logic [1:0]    cfg_word_size_i;
    logic          cfg_sign_ext_i;

    modport slave (
        input  data_i, data_valid_i, sample_ready_i,
        input  cfg_en_i, cfg_word_size_i, cfg_sign_ext_i,
        output data_ready_o, sample_o, sample_valid_o, level_o, err_underrun_o
    );

    modport master (
        output data_i, data_valid_i, sample_ready_i,
        output cfg_en_i, cfg_word_size_i, cfg_sign_ext_i,
        input  data_ready_o, sample_o, sample_valid_o, level_o, err_underrun_o
    );
endinterface

// File: rtl/i2s_tx_sample_unpacker.sv
// ---------------------------------------------------------------------------
// i2s_tx_sample_unpacker
//
// Splits 32-bit memory words into 8-, 16- or 32-bit audio samples (lane 0 is
// the least significant lane), right-justifies and optionally sign-extends
// each one, and queues them in a small sample FIFO feeding the I2S TX DSP
// channel. Also raises a sticky underrun flag when the consumer asks for a
// sample after streaming has started but the FIFO is empty.
//
// Ports:
//   sck_i  - I2S bit clock, the only clock
//   rst_i  - synchronous active-high reset
//   bus    - slave side of i2s_tx_sample_unpacker_if (word stream in,
//            sample stream out, level/underrun status, configuration)
//
// Parameter FIFO_DEPTH must be a power of two, at least 2, and equal to the
// FIFO_DEPTH of the connected interface.
// ---------------------------------------------------------------------------
module i2s_tx_sample_unpacker #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     sck_i,
    input  logic                     rst_i,
    i2s_tx_sample_unpacker_if.slave  bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    logic          wordValid_q, wordValid_d;
    logic [31:0]   word_q, word_d;
    logic [1:0]    lane_q, lane_d;
    logic [AW-1:0] wrPtr_q, wrPtr_d;
    logic [AW-1:0] rdPtr_q, rdPtr_d;
    logic [LW-1:0] level_q, level_d;
    logic          primed_q, primed_d;
    logic          underrun_q, underrun_d;
    logic [31:0]   mem_q [FIFO_DEPTH];

    logic [7:0]    byteLane;
    logic [15:0]   halfLane;
    logic [31:0]   laneSample;
    logic          lastLane;
    logic          fifoFull, fifoEmpty;
    logic          push, pop, dataReady, accept;

    // Pick the current lane out of the held word and widen it to 32 bits.
    // lastLane marks the lane after which the word is fully consumed.
    always_comb begin
        byteLane   = word_q[7:0];
        halfLane   = word_q[15:0];
        laneSample = word_q;
        lastLane   = 1'b1;
        case (lane_q)
            2'd0:    byteLane = word_q[7:0];
            2'd1:    byteLane = word_q[15:8];
            2'd2:    byteLane = word_q[23:16];
            default: byteLane = word_q[31:24];
        endcase
        halfLane = (lane_q == 2'd1) ? word_q[31:16] : word_q[15:0];
        case (bus.cfg_word_size_i)
            2'd0: begin
                laneSample = {{24{bus.cfg_sign_ext_i & byteLane[7]}}, byteLane};
                lastLane   = (lane_q == 2'd3);
            end
            2'd1: begin
                laneSample = {{16{bus.cfg_sign_ext_i & halfLane[15]}}, halfLane};
                lastLane   = (lane_q == 2'd1);
            end
            default: begin
                laneSample = word_q;
                lastLane   = 1'b1;
            end
        endcase
    end

    assign fifoFull  = (level_q == LW'(FIFO_DEPTH));
    assign fifoEmpty = (level_q == '0);
    // A pop in the same cycle does not free a slot for this cycle's push.
    assign push      = bus.cfg_en_i & wordValid_q & ~fifoFull;
    assign pop       = bus.sample_ready_i & ~fifoEmpty;
    // Taking a new word alongside the final lane push keeps the stream gap-free.
    assign dataReady = bus.cfg_en_i & (~wordValid_q | (push & lastLane));
    assign accept    = bus.data_valid_i & dataReady;

    // Next-state logic; dropping cfg_en_i flushes everything on the next edge.
    always_comb begin
        wordValid_d = wordValid_q;
        word_d      = word_q;
        lane_d      = lane_q;
        wrPtr_d     = wrPtr_q;
        rdPtr_d     = rdPtr_q;
        level_d     = level_q;
        primed_d    = primed_q;
        underrun_d  = underrun_q;

        if (push) begin
            wrPtr_d = wrPtr_q + AW'(1);
            if (lastLane) begin
                wordValid_d = 1'b0;
                lane_d      = 2'd0;
            end else begin
                lane_d = lane_q + 2'd1;
            end
        end
        if (accept) begin
            word_d      = bus.data_i;
            wordValid_d = 1'b1;
            lane_d      = 2'd0;
        end
        if (pop) begin
            rdPtr_d  = rdPtr_q + AW'(1);
            primed_d = 1'b1;
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        if (primed_q && bus.sample_ready_i && fifoEmpty) begin
            underrun_d = 1'b1;
        end

        if (!bus.cfg_en_i) begin
            wordValid_d = 1'b0;
            lane_d      = 2'd0;
            wrPtr_d     = '0;
            rdPtr_d     = '0;
            level_d     = '0;
            primed_d    = 1'b0;
            underrun_d  = 1'b0;
        end
    end

    // Control state register.
    always_ff @(posedge sck_i) begin
        if (rst_i) begin
            wordValid_q <= 1'b0;
            word_q      <= '0;
            lane_q      <= 2'd0;
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            level_q     <= '0;
            primed_q    <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            wordValid_q <= wordValid_d;
            word_q      <= word_d;
            lane_q      <= lane_d;
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            level_q     <= level_d;
            primed_q    <= primed_d;
            underrun_q  <= underrun_d;
        end
    end

    // Sample storage; stale contents are never visible because sample_o is
    // forced to zero while the FIFO is empty.
    always_ff @(posedge sck_i) begin
        if (push) begin
            mem_q[wrPtr_q] <= laneSample;
        end
    end

    assign bus.data_ready_o   = dataReady;
    assign bus.sample_o       = fifoEmpty ? 32'h0 : mem_q[rdPtr_q];
    assign bus.sample_valid_o = ~fifoEmpty;
    assign bus.level_o        = level_q;
    assign bus.err_underrun_o = underrun_q;
endmodule

// File: tb/tb_i2s_tx_sample_unpacker.sv
// ---------------------------------------------------------------------------
// tb_i2s_tx_sample_unpacker
//
// Directed bench for i2s_tx_sample_unpacker with FIFO_DEPTH = 4. Inputs are
// driven and outputs sampled on the falling edge of sck. A monitor records
// every sample that will be popped on the next rising edge, together with the
// cycle it was seen, so ordering and back-to-back throughput can be checked
// against hand-computed expected lists.
// ---------------------------------------------------------------------------
module tb_i2s_tx_sample_unpacker;
    localparam int DEPTH = 4;

    logic sck = 1'b0;
    logic rst;

    int          checks = 0;
    int          errors = 0;
    int          cycle  = 0;
    logic [31:0] popQ [$];
    int          popCyc [$];
    logic [31:0] expVals [16];

    // Bit clock, 10 time units per period.
    always #5 sck = ~sck;

    i2s_tx_sample_unpacker_if #(.FIFO_DEPTH(DEPTH)) bus ();

    i2s_tx_sample_unpacker #(.FIFO_DEPTH(DEPTH)) dut (
        .sck_i (sck),
        .rst_i (rst),
        .bus   (bus)
    );

    // Record each sample that the consumer will take at the next rising edge.
    always @(negedge sck) begin
        cycle <= cycle + 1;
        if (!rst && bus.cfg_en_i && bus.sample_ready_i && bus.sample_valid_o) begin
            popQ.push_back(bus.sample_o);
            popCyc.push_back(cycle);
        end
    end

    // Single comparison point: counts the check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Present one word and hold it until the unpacker takes it (bounded).
    // Called on a falling edge; returns on the falling edge after acceptance.
    task automatic applyStimulus(input logic [31:0] word);
        int guard;
        guard = 0;
        bus.data_i       = word;
        bus.data_valid_i = 1'b1;
        while (!bus.data_ready_o && guard < 50) begin
            @(negedge sck);
            guard++;
        end
        checkOutput("acceptReady", {31'b0, bus.data_ready_o}, 32'h1);
        @(negedge sck);
        bus.data_valid_i = 1'b0;
    endtask

    // Disable for one edge (flush), load a new configuration, re-enable.
    task automatic enableWith(input logic [1:0] size, input logic sign);
        bus.cfg_en_i = 1'b0;
        @(negedge sck);
        bus.cfg_word_size_i = size;
        bus.cfg_sign_ext_i  = sign;
        bus.cfg_en_i        = 1'b1;
        @(negedge sck);
    endtask

    task automatic setExp4(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] c, input logic [31:0] d);
        expVals[0] = a;
        expVals[1] = b;
        expVals[2] = c;
        expVals[3] = d;
    endtask

    task automatic clearPops();
        popQ.delete();
        popCyc.delete();
    endtask

    // Compare the recorded pops against the first n entries of expVals.
    task automatic checkPops(input string tag, input int n);
        logic [31:0] got;
        checkOutput({tag, "Count"}, 32'(popQ.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            got = (i < popQ.size()) ? popQ[i] : 32'hBAD0_BAD0;
            checkOutput(tag, got, expVals[i]);
        end
    endtask

    initial begin
        int i;
        int guard;

        rst                 = 1'b1;
        bus.cfg_en_i        = 1'b0;
        bus.cfg_word_size_i = 2'd0;
        bus.cfg_sign_ext_i  = 1'b0;
        bus.data_i          = 32'h0;
        bus.data_valid_i    = 1'b0;
        bus.sample_ready_i  = 1'b0;
        repeat (3) @(negedge sck);

        // Reset state
        checkOutput("rstDataReady", {31'b0, bus.data_ready_o}, 32'h0);
        checkOutput("rstSampleValid", {31'b0, bus.sample_valid_o}, 32'h0);
        checkOutput("rstSample", bus.sample_o, 32'h0);
        checkOutput("rstLevel", 32'(bus.level_o), 32'h0);
        checkOutput("rstErr", {31'b0, bus.err_underrun_o}, 32'h0);
        rst = 1'b0;
        enableWith(2'd0, 1'b1);
        checkOutput("enDataReady", {31'b0, bus.data_ready_o}, 32'h1);

        // 8-bit sign-extend
        clearPops();
        bus.sample_ready_i = 1'b1;
        applyStimulus(32'h80FF7F01);
        checkOutput("t1ReadyBusy", {31'b0, bus.data_ready_o}, 32'h0);
        repeat (4) @(negedge sck);
        checkOutput("t1ReadyAgain", {31'b0, bus.data_ready_o}, 32'h1);
        repeat (4) @(negedge sck);
        setExp4(32'h00000001, 32'h0000007F, 32'hFFFFFFFF, 32'hFFFFFF80);
        checkPops("t1Pop", 4);

        // 16-bit zero-extend, then sign-extend
        enableWith(2'd1, 1'b0);
        clearPops();
        applyStimulus(32'h80001234);
        repeat (6) @(negedge sck);
        setExp4(32'h00001234, 32'h00008000, 32'h0, 32'h0);
        checkPops("t2Zero", 2);

        enableWith(2'd1, 1'b1);
        clearPops();
        applyStimulus(32'h80001234);
        repeat (6) @(negedge sck);
        setExp4(32'h00001234, 32'hFFFF8000, 32'h0, 32'h0);
        checkPops("t2Sign", 2);

        // 32-bit throughput: one word accepted and one sample popped per cycle
        enableWith(2'd2, 1'b0);
        clearPops();
        i     = 0;
        guard = 0;
        bus.data_i       = 32'h0;
        bus.data_valid_i = 1'b1;
        while (i < 16 && guard < 200) begin
            if (bus.data_ready_o) i++;
            @(negedge sck);
            bus.data_i = 32'(i);
            guard++;
        end
        bus.data_valid_i = 1'b0;
        checkOutput("t3Accepted", 32'(i), 32'd16);
        repeat (6) @(negedge sck);
        for (int k = 0; k < 16; k++) expVals[k] = 32'(k);
        checkPops("t3Pop", 16);
        checkOutput("t3Span",
                    (popCyc.size() >= 16) ? 32'(popCyc[15] - popCyc[0]) : 32'hFFFF_FFFF,
                    32'd15);

        // Backpressure: FIFO fills to 4, second word stalls, then drains in order
        enableWith(2'd0, 1'b0);
        clearPops();
        bus.sample_ready_i = 1'b0;
        applyStimulus(32'h04030201);
        checkOutput("t4ReadyBusy", {31'b0, bus.data_ready_o}, 32'h0);
        applyStimulus(32'h08070605);
        checkOutput("t4LevelFull", 32'(bus.level_o), 32'd4);
        checkOutput("t4Stalled", {31'b0, bus.data_ready_o}, 32'h0);
        repeat (2) @(negedge sck);
        checkOutput("t4LevelHold", 32'(bus.level_o), 32'd4);
        bus.sample_ready_i = 1'b1;
        repeat (14) @(negedge sck);
        for (int k = 0; k < 8; k++) expVals[k] = 32'(k + 1);
        checkPops("t4Pop", 8);

        // Underrun: drain with ready held, flag rises one edge after empty
        enableWith(2'd0, 1'b0);
        checkOutput("t5ErrCleared", {31'b0, bus.err_underrun_o}, 32'h0);
        checkOutput("t5LevelCleared", 32'(bus.level_o), 32'h0);
        bus.sample_ready_i = 1'b0;
        applyStimulus(32'h04030201);
        guard = 0;
        while (bus.level_o != 3'd4 && guard < 20) begin
            @(negedge sck);
            guard++;
        end
        checkOutput("t5Filled", 32'(bus.level_o), 32'd4);
        bus.sample_ready_i = 1'b1;
        guard = 0;
        while (bus.level_o != 3'd0 && guard < 20) begin
            @(negedge sck);
            guard++;
        end
        checkOutput("t5Drained", 32'(bus.level_o), 32'h0);
        checkOutput("t5ErrNotYet", {31'b0, bus.err_underrun_o}, 32'h0);
        @(negedge sck);
        checkOutput("t5ErrSet", {31'b0, bus.err_underrun_o}, 32'h1);
        repeat (2) @(negedge sck);
        checkOutput("t5ErrSticky", {31'b0, bus.err_underrun_o}, 32'h1);
        bus.cfg_en_i = 1'b0;
        @(negedge sck);
        checkOutput("t5ErrFlushed", {31'b0, bus.err_underrun_o}, 32'h0);
        checkOutput("t5LevelFlushed", 32'(bus.level_o), 32'h0);
        checkOutput("t5ReadyDisabled", {31'b0, bus.data_ready_o}, 32'h0);
        bus.cfg_en_i = 1'b1;
        repeat (2) @(negedge sck);
        checkOutput("t5ErrUnprimed", {31'b0, bus.err_underrun_o}, 32'h0);

        // Flush mid-word: partial lanes discarded, new word unpacks cleanly
        enableWith(2'd0, 1'b0);
        bus.sample_ready_i = 1'b0;
        applyStimulus(32'hDDCCBBAA);
        repeat (2) @(negedge sck);
        checkOutput("t6LevelPartial", 32'(bus.level_o), 32'd2);
        bus.cfg_en_i = 1'b0;
        @(negedge sck);
        checkOutput("t6LevelFlushed", 32'(bus.level_o), 32'h0);
        checkOutput("t6ValidFlushed", {31'b0, bus.sample_valid_o}, 32'h0);
        bus.cfg_en_i       = 1'b1;
        bus.sample_ready_i = 1'b1;
        clearPops();
        @(negedge sck);
        applyStimulus(32'h44332211);
        repeat (8) @(negedge sck);
        setExp4(32'h00000011, 32'h00000022, 32'h00000033, 32'h00000044);
        checkPops("t6Pop", 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard stop in case anything above stalls unexpectedly.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule

// File: doc/i2s_tx_sample_unpacker.md
# i2s_tx_sample_unpacker

Upstream feeder for the I2S TX DSP channel. It takes 32-bit memory words arriving from the TX data FIFO, already in the `sck_i` domain. It unpacks them into 8-, 16- or 32-bit audio samples, right-justifies each one and optionally sign-extends it, then buffers the samples in a small sample FIFO. That FIFO drives the channel's `fifo_data_i`/`fifo_data_valid_i`/`fifo_data_ready_o` handshake and also reports underruns.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4: sample FIFO entries. Must be a power of two and at least 2.

Ports:
- `sck_i` input 1: I2S bit clock; the only clock.
- `rst_i` input 1: synchronous reset, active-high.
- `data_i` input 32: packed word from the upstream FIFO.
- `data_valid_i` input 1: `data_i` is valid.
- `data_ready_o` output 1: the block accepts `data_i` this cycle.
- `sample_o` output 32: head sample. Connects to `fifo_data_i`.
- `sample_valid_o` output 1: the FIFO is not empty. Connects to `fifo_data_valid_i`.
- `sample_ready_i` input 1: the consumer pops the head. Connects to `fifo_data_ready_o`.
- `level_o` output $clog2(FIFO_DEPTH)+1: number of samples held in the FIFO.
- `err_underrun_o` output 1: sticky underrun flag.
- `cfg_en_i` input 1: enable. When low, the block flushes and holds.
- `cfg_word_size_i` input 2: sample size. 0 = 8-bit, 1 = 16-bit, 2 or 3 = 32-bit.
- `cfg_sign_ext_i` input 1: 1 = sign-extend samples to 32 bits, 0 = zero-extend.

## Operation
- Word register: `wvld` plus the 32-bit word. Lane counter `lane` is 2 bits.
- Samples per word (SPW): 4, 2 or 1, set by `cfg_word_size_i`.
- Lane order is little-endian:
  - Lane k for 8-bit samples is `word[8k+7:8k]`.
  - Lane k for 16-bit samples is `word[16k+15:16k]`.
- Each lane is right-justified into bits [N-1:0]. Upper bits are filled with copies of bit N-1 when `cfg_sign_ext_i`=1, otherwise with zeros.
- Push: when `wvld`=1 and `level_o` < FIFO_DEPTH, the current lane is written into the FIFO.
  - If `lane` = SPW-1, the push also clears `wvld` and sets `lane` to 0.
  - Otherwise `lane` increments.
- Push is not allowed when `level_o` = FIFO_DEPTH, even if a pop happens in the same cycle.
- `data_ready_o` = `cfg_en_i` & (!`wvld` | (push & `lane`==SPW-1)).
  - This lets a new word load in the same cycle as the last lane push, giving gap-free throughput.
- Accept (`data_valid_i` & `data_ready_o`): load the word, set `wvld`=1, set `lane`=0.
- Pop: `sample_ready_i` & `sample_valid_o`.
  - `sample_ready_i` while empty is ignored.
- Simultaneous push and pop leave `level_o` unchanged. Pointers wrap modulo FIFO_DEPTH.
- `sample_o` is the head entry when the FIFO is non-empty, and 0 when it is empty.
- Underrun:
  - `primed` is set on the first pop after enable.
  - `err_underrun_o` is set when `cfg_en_i` & `primed` & `sample_ready_i` & (`level_o`==0).
  - It stays set until `cfg_en_i`=0 or `rst_i`.
- `cfg_en_i`=0 acts as a synchronous flush on the next edge. It clears `wvld`, `lane`, FIFO pointers, `level_o`, `primed` and `err_underrun_o`. While it is low, `data_ready_o`=0.
- `cfg_word_size_i` and `cfg_sign_ext_i` must remain static while `cfg_en_i`=1. Changing them while enabled is unsupported.
- Reset mid-operation has the same effect as a flush. Samples in flight are discarded. The partially consumed word is dropped and is not re-requested.

## Timing
- Values after reset:
  - `data_ready_o`=0 while `cfg_en_i`=0, otherwise 1 in the first cycle after reset.
  - `sample_valid_o`=0, `sample_o`=0, `level_o`=0, `err_underrun_o`=0.
- Latency from a word accepted at edge E0:
  - Lane 0 is pushed at E1.
  - `sample_valid_o` rises in the cycle after E1.
  - Later lanes are pushed at E2, E3, … as long as the FIFO is not full.
- Sustained throughput is one sample per cycle in all sizes. 32-bit mode therefore accepts one word per cycle.
- A pop at edge E frees a slot for a push at E+1.
- `level_o` and `sample_valid_o` are registered-count derived. They change only on edges.
- `err_underrun_o` is set at the edge that sees the underrun condition.

## Test plan
- **8-bit sign-extend:** size=0, sign=1, word 0x80FF7F01, consumer always ready. Required: pops of 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80 in that order. `data_ready_o` is high again in the cycle after the lane-3 push.
- **16-bit zero vs sign:** size=1, word 0x80001234. With sign=0 the required pops are 0x00001234, 0x00008000. With sign=1 they are 0x00001234, 0xFFFF8000.
- **32-bit throughput:** size=2, 16 consecutive words 0x0..0xF presented with `data_valid_i` held high, consumer always ready. Required: 16 back-to-back pops matching the inputs in order, and `sample_valid_o` continuously high after the first pop.
- **Backpressure:** `sample_ready_i`=0, size=0, two words presented, FIFO_DEPTH=4.
  - Required: `level_o` saturates at 4 and the second word's accept is stalled (`data_ready_o`=0).
  - Then release `sample_ready_i`. Required: all 8 samples come out in order with none lost.
- **Underrun:** pop one sample, stop `data_valid_i`, hold `sample_ready_i`=1 until empty.
  - Required: `err_underrun_o`=1 from the first edge at which `level_o`=0 with ready asserted.
  - Drop `cfg_en_i` for one cycle. Required: `err_underrun_o`=0, `level_o`=0.
- **Flush mid-word:** size=0, drop `cfg_en_i` after two lanes have been pushed, then re-enable and send a new word 0x44332211. Required: `level_o`=0 after the flush, and the next pops are 0x11, 0x22, 0x33, 0x44 with no stale lanes.
